seven_segment_monitor: RTL

//  Receiving end of the multiplexed seven-segment display interface: watches anode/segment as

---
 rtl/seven_segment_monitor.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/seven_segment_monitor.sv
// Seven-segment scan monitor: samples a multiplexed anode/segment bus
// and rebuilds the displayed hex value, blank flags and decimal points.
module seven_segment_monitor #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode,
  input  logic [7:0]  segment,
  output logic [15:0] data_out,
  output logic [3:0]  digit_display,
  output logic [3:0]  digit_point,
  output logic [3:0]  digit_err,
  output logic        frame_strobe,
  output logic        display_active
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SMAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPT} state_t;

  state_t state, nstate;

  logic [3:0] a_s1, a_s2, a_p;
  logic [7:0] s_s1, s_s2, s_p;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic [3:0] seen;

  logic [15:0] sh_data, nx_data;
  logic [3:0] sh_dis, nx_dis;
  logic [3:0] sh_pt, nx_pt;
  logic [3:0] sh_err, nx_err;

  logic valid, chg, settled, cap, frame, tmo;
  logic [1:0] idx;
  logic [6:0] seg7;
  logic [3:0] d_nib;
  logic d_dis, d_err;

  // 2-flop synchronisers plus a one-cycle history for change detection
  always_ff @(posedge clk) begin
    if (reset) begin
      a_s1 <= 4'hF;
      a_s2 <= 4'hF;
      a_p  <= 4'hF;
      s_s1 <= 8'hFF;
      s_s2 <= 8'hFF;
      s_p  <= 8'hFF;
    end else begin
      a_s1 <= anode;
      a_s2 <= a_s1;
      a_p  <= a_s2;
      s_s1 <= segment;
      s_s2 <= s_s1;
      s_p  <= s_s2;
    end
  end

  always_comb begin
    valid = 1'b1;
    idx   = 2'd0;
    unique case (1'b1)
      (a_s2 == 4'b1110): idx = 2'd0;
      (a_s2 == 4'b1101): idx = 2'd1;
      (a_s2 == 4'b1011): idx = 2'd2;
      (a_s2 == 4'b0111): idx = 2'd3;
      default:           valid = 1'b0;
    endcase
  end

  assign chg     = (a_s2 != a_p) || (s_s2 != s_p);
  assign settled = valid && !chg && (scnt == SMAX);
  assign frame   = (seen == 4'hF);
  assign tmo     = (tcnt == TMAX);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:   if (valid) nstate = SETTLE;
      SETTLE: begin
        if (!valid)       nstate = IDLE;
        else if (settled) nstate = CAPT;
      end
      CAPT: begin
        if (!valid)   nstate = IDLE;
        else if (chg) nstate = SETTLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    cap = (state == SETTLE) && settled;
  end

  assign seg7 = ~s_s2[6:0];

  always_comb begin
    d_nib = 4'h0;
    d_dis = 1'b1;
    d_err = 1'b0;
    case (seg7)
      7'h3F: d_nib = 4'h0;
      7'h06: d_nib = 4'h1;
      7'h5B: d_nib = 4'h2;
      7'h4F: d_nib = 4'h3;
      7'h66: d_nib = 4'h4;
      7'h6D: d_nib = 4'h5;
      7'h7D: d_nib = 4'h6;
      7'h07: d_nib = 4'h7;
      7'h7F: d_nib = 4'h8;
      7'h6F: d_nib = 4'h9;
      7'h77: d_nib = 4'hA;
      7'h7C: d_nib = 4'hB;
      7'h39: d_nib = 4'hC;
      7'h5E: d_nib = 4'hD;
      7'h79: d_nib = 4'hE;
      7'h71: d_nib = 4'hF;
      7'h00: d_dis = 1'b0;
      default: d_err = 1'b1;
    endcase
  end

  // shadow view with this cycle's capture folded in, so a capture
  // landing on the frame cycle is part of that frame
  always_comb begin
    nx_data = sh_data;
    nx_dis  = sh_dis;
    nx_pt   = sh_pt;
    nx_err  = sh_err;
    if (cap) begin
      nx_data[idx*4 +: 4] = d_nib;
      nx_dis[idx]         = d_dis;
      nx_pt[idx]          = ~s_s2[7];
      nx_err[idx]         = d_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scnt           <= '0;
      tcnt           <= '0;
      seen           <= 4'h0;
      sh_data        <= 16'h0;
      sh_dis         <= 4'h0;
      sh_pt          <= 4'h0;
      sh_err         <= 4'h0;
      data_out       <= 16'h0;
      digit_display  <= 4'h0;
      digit_point    <= 4'h0;
      digit_err      <= 4'h0;
      frame_strobe   <= 1'b0;
      display_active <= 1'b0;
    end else begin
      scnt <= (state == SETTLE && valid && !chg && scnt != SMAX)
            ? scnt + 1'b1 : '0;
      if (cap)       tcnt <= '0;
      else if (!tmo) tcnt <= tcnt + 1'b1;
      sh_data      <= nx_data;
      sh_dis       <= nx_dis;
      sh_pt        <= nx_pt;
      sh_err       <= nx_err;
      frame_strobe <= frame;
      if (frame) begin
        data_out       <= nx_data;
        digit_display  <= nx_dis;
        digit_point    <= nx_pt;
        digit_err      <= nx_err;
        seen           <= 4'h0;
        display_active <= 1'b1;
      end else if (tmo && !cap) begin
        seen           <= 4'h0;
        display_active <= 1'b0;
      end else if (cap) begin
        seen[idx] <= 1'b1;
      end
    end
  end

endmodule
